// File: rtl/uwoc_rx_pkg.sv
// Shared definitions for the UWOC RX debug blocks.
//   - scan_state_e : state encoding of the phase peak scanner
//   - DefThOn/Off  : default peak_good hysteresis thresholds
//   - UWOC_PHASE_SLICE(vec, k, w) : selects phase k from a flat per-phase count bus

`ifndef UWOC_PHASE_SLICE
`define UWOC_PHASE_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package uwoc_rx_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } scan_state_e;

    localparam int unsigned DefThOn  = 50;
    localparam int unsigned DefThOff = 30;

endpackage

// File: rtl/phase_peak_qualifier.sv
// Qualifies each published peak: hysteresis on the margin (peak_good) and a
// saturating count of consecutive good scans with an unchanged max index.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clr_i           synchronous clear of all history
//   publish_i       one-cycle strobe, inputs below are valid
//   idx_i           max index of the scan being published
//   margin_i        max - second of that scan
//   th_on_i/off_i   hysteresis thresholds, sampled on publish only
//   peak_good_o     hysteresis-qualified peak flag
//   stable_cnt_o    consecutive good scans with the same index (saturating)
//   peak_stable_o   stable_cnt_o has reached STABLE_SCANS

module phase_peak_qualifier #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned STABLE_SCANS = 4,
    parameter int unsigned STB_W        = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 publish_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [CNT_WIDTH-1:0] margin_i,
    input  logic [CNT_WIDTH-1:0] th_on_i,
    input  logic [CNT_WIDTH-1:0] th_off_i,
    output logic                 peak_good_o,
    output logic [STB_W-1:0]     stable_cnt_o,
    output logic                 peak_stable_o
);

    localparam logic [STB_W-1:0] StbMax = STB_W'(STABLE_SCANS);

    logic             good_q, good_d;
    logic             prev_valid_q, prev_valid_d;
    logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
    logic [STB_W-1:0] stb_q, stb_d;

    always_comb begin
        good_d       = good_q;
        prev_valid_d = prev_valid_q;
        prev_idx_d   = prev_idx_q;
        stb_d        = stb_q;
        if (publish_i) begin
            good_d = good_q ? (margin_i >= th_off_i) : (margin_i >= th_on_i);
            if (!good_d) begin
                stb_d = '0;
            end else if (prev_valid_q && (idx_i == prev_idx_q)) begin
                stb_d = (stb_q == StbMax) ? StbMax : stb_q + STB_W'(1);
            end else begin
                stb_d = STB_W'(1);
            end
            prev_valid_d = 1'b1;
            prev_idx_d   = idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            good_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_idx_q   <= '0;
            stb_q        <= '0;
        end else if (clr_i) begin
            good_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_idx_q   <= '0;
            stb_q        <= '0;
        end else begin
            good_q       <= good_d;
            prev_valid_q <= prev_valid_d;
            prev_idx_q   <= prev_idx_d;
            stb_q        <= stb_d;
        end
    end

    assign peak_good_o   = good_q;
    assign stable_cnt_o  = stb_q;
    assign peak_stable_o = (stb_q == StbMax);

endmodule

// File: rtl/rx_phase_peak_scan.sv
// Sequential phase-count peak finder. Snapshots the per-phase counts, scans one
// phase per clock keeping max/second/index, then publishes the result for one
// cycle (result_vld_o) and holds it until the next publish.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   clr_i             synchronous clear: abort scan, drop history, zero outputs
//   scan_start_i      one-cycle scan request (ignored while scanning)
//   auto_rescan_i     level: start a new scan back-to-back
//   phase_count_i     flat count bus, phase k at [k*CNT_WIDTH +: CNT_WIDTH]
//   th_on_i/th_off_i  peak_good hysteresis thresholds
//   busy_o            FSM not idle
//   result_vld_o      pulse, published outputs just updated
//   max_idx_o, max_cnt_o, second_cnt_o, margin_o, tie_o   published scan result
//   peak_good_o, peak_stable_o, stable_cnt_o              qualification
//   scan_count_o      number of published results (wraps)

module rx_phase_peak_scan
    import uwoc_rx_pkg::*;
#(
    parameter int unsigned NUM_PHASE    = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned STABLE_SCANS = 4,
    localparam int unsigned IDX_W       = $clog2(NUM_PHASE),
    localparam int unsigned STB_W       = $clog2(STABLE_SCANS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           scan_start_i,
    input  logic                           auto_rescan_i,
    input  logic [NUM_PHASE*CNT_WIDTH-1:0] phase_count_i,
    input  logic [CNT_WIDTH-1:0]           th_on_i,
    input  logic [CNT_WIDTH-1:0]           th_off_i,
    output logic                           busy_o,
    output logic                           result_vld_o,
    output logic [IDX_W-1:0]               max_idx_o,
    output logic [CNT_WIDTH-1:0]           max_cnt_o,
    output logic [CNT_WIDTH-1:0]           second_cnt_o,
    output logic [CNT_WIDTH-1:0]           margin_o,
    output logic                           tie_o,
    output logic                           peak_good_o,
    output logic                           peak_stable_o,
    output logic [STB_W-1:0]               stable_cnt_o,
    output logic [31:0]                    scan_count_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PHASE - 1);

    scan_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] snap_q [NUM_PHASE];
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] wmax_q, wmax_d;
    logic [CNT_WIDTH-1:0] wsec_q, wsec_d;
    logic [IDX_W-1:0]     widx_q, widx_d;

    logic [IDX_W-1:0]     max_idx_q;
    logic [CNT_WIDTH-1:0] max_cnt_q, second_cnt_q, margin_q;
    logic                 tie_q, result_vld_q;
    logic [31:0]          scan_count_q;

    logic                 start;
    logic                 load_snap;
    logic                 publish;
    logic [CNT_WIDTH-1:0] cur;
    logic [CNT_WIDTH-1:0] margin_w;

    assign start    = scan_start_i | auto_rescan_i;
    assign cur      = snap_q[ptr_q];
    // Second never exceeds max, so this cannot underflow.
    assign margin_w = wmax_q - wsec_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wmax_d    = wmax_q;
        wsec_d    = wsec_q;
        widx_d    = widx_q;
        load_snap = 1'b0;
        publish   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StScan;
                    load_snap = 1'b1;
                    ptr_d     = '0;
                    wmax_d    = '0;
                    wsec_d    = '0;
                    widx_d    = '0;
                end
            end
            StScan: begin
                // Strict compares: on equal counts the earlier index keeps the max.
                if (cur > wmax_q) begin
                    wsec_d = wmax_q;
                    wmax_d = cur;
                    widx_d = ptr_q;
                end else if (cur > wsec_q) begin
                    wsec_d = cur;
                end
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                publish = 1'b1;
                if (start) begin
                    state_d   = StScan;
                    load_snap = 1'b1;
                    ptr_d     = '0;
                    wmax_d    = '0;
                    wsec_d    = '0;
                    widx_d    = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NUM_PHASE); k++) snap_q[k] <= '0;
        end else if (load_snap && !clr_i) begin
            for (int k = 0; k < int'(NUM_PHASE); k++) begin
                snap_q[k] <= `UWOC_PHASE_SLICE(phase_count_i, k, CNT_WIDTH);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            wmax_q       <= '0;
            wsec_q       <= '0;
            widx_q       <= '0;
            max_idx_q    <= '0;
            max_cnt_q    <= '0;
            second_cnt_q <= '0;
            margin_q     <= '0;
            tie_q        <= 1'b0;
            result_vld_q <= 1'b0;
            scan_count_q <= '0;
        end else if (clr_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            wmax_q       <= '0;
            wsec_q       <= '0;
            widx_q       <= '0;
            max_idx_q    <= '0;
            max_cnt_q    <= '0;
            second_cnt_q <= '0;
            margin_q     <= '0;
            tie_q        <= 1'b0;
            result_vld_q <= 1'b0;
            scan_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wmax_q       <= wmax_d;
            wsec_q       <= wsec_d;
            widx_q       <= widx_d;
            result_vld_q <= publish;
            if (publish) begin
                max_idx_q    <= widx_q;
                max_cnt_q    <= wmax_q;
                second_cnt_q <= wsec_q;
                margin_q     <= margin_w;
                tie_q        <= (margin_w == '0);
                scan_count_q <= scan_count_q + 32'd1;
            end
        end
    end

    phase_peak_qualifier #(
        .CNT_WIDTH    (CNT_WIDTH),
        .IDX_W        (IDX_W),
        .STABLE_SCANS (STABLE_SCANS),
        .STB_W        (STB_W)
    ) u_qualifier (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (clr_i),
        .publish_i     (publish),
        .idx_i         (widx_q),
        .margin_i      (margin_w),
        .th_on_i       (th_on_i),
        .th_off_i      (th_off_i),
        .peak_good_o   (peak_good_o),
        .stable_cnt_o  (stable_cnt_o),
        .peak_stable_o (peak_stable_o)
    );

    assign busy_o       = (state_q != StIdle);
    assign result_vld_o = result_vld_q;
    assign max_idx_o    = max_idx_q;
    assign max_cnt_o    = max_cnt_q;
    assign second_cnt_o = second_cnt_q;
    assign margin_o     = margin_q;
    assign tie_o        = tie_q;
    assign scan_count_o = scan_count_q;

endmodule

// File: tb/tb_rx_phase_peak_scan.sv
// Bench for rx_phase_peak_scan: a transaction-level model (countdown + argmax over
// the snapshot) is compared against every output on every falling edge, and the
// directed scenarios add hand-computed literal expectations.

module tb_rx_phase_peak_scan;
    import uwoc_rx_pkg::*;

    localparam int N  = 16;
    localparam int CW = 16;
    localparam int IW = 4;
    localparam int S  = 4;

    logic             clk = 1'b0;
    logic             rst_n, clr, scan_start, auto_rescan;
    logic [N*CW-1:0]  phase_count;
    logic [CW-1:0]    th_on, th_off;
    logic             busy, result_vld, tie, peak_good, peak_stable;
    logic [IW-1:0]    max_idx;
    logic [CW-1:0]    max_cnt, second_cnt, margin;
    logic [2:0]       stable_cnt;
    logic [31:0]      scan_count;

    logic [CW-1:0]    cnts [N];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             cmp_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        phase_count = '0;
        for (int k = 0; k < N; k++) phase_count[k*CW +: CW] = cnts[k];
    end

    rx_phase_peak_scan #(
        .NUM_PHASE    (N),
        .CNT_WIDTH    (CW),
        .STABLE_SCANS (S)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (clr),
        .scan_start_i  (scan_start),
        .auto_rescan_i (auto_rescan),
        .phase_count_i (phase_count),
        .th_on_i       (th_on),
        .th_off_i      (th_off),
        .busy_o        (busy),
        .result_vld_o  (result_vld),
        .max_idx_o     (max_idx),
        .max_cnt_o     (max_cnt),
        .second_cnt_o  (second_cnt),
        .margin_o      (margin),
        .tie_o         (tie),
        .peak_good_o   (peak_good),
        .peak_stable_o (peak_stable),
        .stable_cnt_o  (stable_cnt),
        .scan_count_o  (scan_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] mx;
        logic [CW-1:0] sec;
    } peak_t;

    function automatic peak_t find_peak(input logic [N*CW-1:0] v);
        peak_t p;
        p.idx = '0;
        for (int k = 1; k < N; k++) begin
            if (v[k*CW +: CW] > v[int'(p.idx)*CW +: CW]) p.idx = IW'(k);
        end
        p.mx  = v[int'(p.idx)*CW +: CW];
        p.sec = '0;
        for (int k = 0; k < N; k++) begin
            if (k != int'(p.idx) && v[k*CW +: CW] > p.sec) p.sec = v[k*CW +: CW];
        end
        return p;
    endfunction

    function automatic logic next_good(input logic old, input int mar, input int on,
                                       input int off);
        return old ? (mar >= off) : (mar >= on);
    endfunction

    function automatic int next_stb(input logic good, input logic same, input int cnt);
        if (!good) return 0;
        if (same) return (cnt + 1 > S) ? S : cnt + 1;
        return 1;
    endfunction

    logic [N*CW-1:0] m_snap;
    int              m_rem;
    logic            m_busy, m_vld, m_tie, m_good, m_pv;
    logic [IW-1:0]   m_idx, m_pidx;
    logic [CW-1:0]   m_max, m_sec, m_mar;
    int              m_stb;
    logic [31:0]     m_cnt;
    peak_t           pk;
    int              pk_mar;
    logic            g_w;
    int              s_w;

    always_comb begin
        pk     = find_peak(m_snap);
        pk_mar = int'(pk.mx) - int'(pk.sec);
        g_w    = next_good(m_good, pk_mar, int'(th_on), int'(th_off));
        s_w    = next_stb(g_w, m_pv && (pk.idx == m_pidx), m_stb);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            m_snap <= '0; m_rem <= 0; m_busy <= 1'b0; m_vld <= 1'b0; m_tie <= 1'b0;
            m_good <= 1'b0; m_pv <= 1'b0; m_idx <= '0; m_pidx <= '0; m_max <= '0;
            m_sec <= '0; m_mar <= '0; m_stb <= 0; m_cnt <= '0;
        end else begin
            m_vld <= 1'b0;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_vld  <= 1'b1;
                    m_idx  <= pk.idx;
                    m_max  <= pk.mx;
                    m_sec  <= pk.sec;
                    m_mar  <= CW'(pk_mar);
                    m_tie  <= (pk_mar == 0);
                    m_good <= g_w;
                    m_stb  <= s_w;
                    m_pv   <= 1'b1;
                    m_pidx <= pk.idx;
                    m_cnt  <= m_cnt + 32'd1;
                    if (scan_start || auto_rescan) begin
                        m_snap <= phase_count;
                        m_rem  <= N + 1;
                    end else begin
                        m_busy <= 1'b0;
                    end
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (scan_start || auto_rescan) begin
                m_snap <= phase_count;
                m_rem  <= N + 1;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_busy);
            chk("result_vld", result_vld, m_vld);
            chk("max_idx", max_idx, m_idx);
            chk("max_cnt", max_cnt, m_max);
            chk("second_cnt", second_cnt, m_sec);
            chk("margin", margin, m_mar);
            chk("tie", tie, m_tie);
            chk("peak_good", peak_good, m_good);
            chk("stable_cnt", stable_cnt, m_stb);
            chk("peak_stable", peak_stable, m_stb == S);
            chk("scan_count", scan_count, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input int v);
        for (int k = 0; k < N; k++) cnts[k] = CW'(v);
    endtask

    // Raises scan_start for one cycle; returns just after the sampling edge E0.
    task automatic start_scan();
        @(posedge clk); #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
    endtask

    // Counts falling edges until result_vld; n-th falling edge follows edge E_{n-1}.
    task automatic wait_vld(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (result_vld) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vld_timeout: got no result_vld, expected one within 40 cycles");
        end
    endtask

    task automatic no_vld(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (result_vld) seen++;
        end
        chk(name, seen, 0);
    endtask

    int n;
    int exp_stb [6] = '{1, 2, 3, 4, 4, 4};

    initial begin
        rst_n = 1'b0; clr = 1'b0; scan_start = 1'b0; auto_rescan = 1'b0;
        th_on = CW'(DefThOn); th_off = CW'(DefThOff);
        set_all(0);
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_scan_count", scan_count, 0);
        chk("reset_stable_cnt", stable_cnt, 0);

        // Ramp k*10
        for (int k = 0; k < N; k++) cnts[k] = CW'(k * 10);
        start_scan();
        wait_vld(n);
        chk("ramp_latency", n - 1, 17);
        chk("ramp_max_idx", max_idx, 15);
        chk("ramp_max_cnt", max_cnt, 150);
        chk("ramp_second", second_cnt, 140);
        chk("ramp_margin", margin, 10);
        chk("ramp_good", peak_good, 0);
        chk("ramp_scan_count", scan_count, 1);

        // Tie between phase 3 and phase 9
        set_all(10); cnts[3] = 500; cnts[9] = 500;
        start_scan();
        wait_vld(n);
        chk("tie_max_idx", max_idx, 3);
        chk("tie_second", second_cnt, 500);
        chk("tie_flag", tie, 1);
        chk("tie_good", peak_good, 0);

        // Hysteresis: margins 60, 40, 25, 55 on phase 2 over four auto scans
        set_all(40); cnts[2] = 100;
        @(posedge clk); #1 auto_rescan = 1'b1;
        repeat (2) @(posedge clk);
        #1 cnts[2] = 80;
        wait_vld(n);
        chk("hyst1_good", peak_good, 1);
        chk("hyst1_stb", stable_cnt, 1);
        chk("hyst1_idx", max_idx, 2);
        @(posedge clk); #1 cnts[2] = 65;
        wait_vld(n);
        chk("auto_period", n, 17);
        chk("hyst2_good", peak_good, 1);
        chk("hyst2_stb", stable_cnt, 2);
        @(posedge clk); #1 cnts[2] = 95;
        wait_vld(n);
        chk("hyst3_good", peak_good, 0);
        chk("hyst3_stb", stable_cnt, 0);
        @(posedge clk); #1 auto_rescan = 1'b0;
        wait_vld(n);
        chk("hyst4_good", peak_good, 1);
        chk("hyst4_stb", stable_cnt, 1);
        chk("hyst4_margin", margin, 55);

        // Stability: phase 5 dominant, six auto scans, then phase 7
        set_all(100); cnts[5] = 300;
        @(posedge clk); #1 auto_rescan = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_vld(n);
            chk("stab_cnt", stable_cnt, exp_stb[i]);
            chk("stab_flag", peak_stable, i >= 3);
            if (i == 4) begin
                @(posedge clk); #1 auto_rescan = 1'b0;
            end
        end
        cnts[5] = 100; cnts[7] = 300;
        start_scan();
        wait_vld(n);
        chk("move_idx", max_idx, 7);
        chk("move_stb", stable_cnt, 1);
        chk("move_stable", peak_stable, 0);

        // Snapshot isolation and ignored start during a scan
        set_all(20); cnts[4] = 900;
        start_scan();
        repeat (3) @(posedge clk);
        #1 cnts[11] = 5000;
        repeat (4) @(posedge clk);
        #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
        wait_vld(n);
        chk("snap_idx", max_idx, 4);
        chk("snap_max", max_cnt, 900);
        no_vld("no_queued_scan", 25);

        // clr at scan cycle 8
        start_scan();
        repeat (7) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_scan_count", scan_count, 0);
        chk("clr_max_cnt", max_cnt, 0);
        chk("clr_good", peak_good, 0);
        no_vld("clr_no_vld", 25);

        // Asynchronous reset at scan cycle 5
        start_scan();
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_max_idx", max_idx, 0);
        chk("arst_scan_count", scan_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        no_vld("arst_no_vld", 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_phase_peak_scan.md
# rx_phase_peak_scan

Sequential, parametrised successor to the combinational phase-count peak finder in the UWOC RX debug path. It snapshots the per-phase pulse counts of the RX gated-clock bank, then scans one phase per cycle. It publishes the max index, max count, second count and margin, plus a hysteresis-qualified `peak_good` and a multi-scan `peak_stable` flag. It sits in the 130 MHz RX domain between `uwoc_rx_chain_gpio` debug counts and the ILA/BER logic, and scales to any phase count without a wide comparator tree.

## Interface
- `NUM_PHASE`, 16, number of phase counters (≥2)
- `CNT_WIDTH`, 16, width of each counter
- `STABLE_SCANS`, 4, consecutive good scans with the same max index needed for `peak_stable` (≥1)
- Derived localparams: `IDX_W = $clog2(NUM_PHASE)`, `STB_W = $clog2(STABLE_SCANS+1)`

Ports:
- `clk` in 1: 130 MHz RX clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear. Aborts any scan and clears history.
- `scan_start` in 1: one-cycle request to scan.
- `auto_rescan` in 1: level. When high, a new scan starts back-to-back.
- `phase_count` in `NUM_PHASE*CNT_WIDTH`: counts, phase k at bits `[k*CNT_WIDTH +: CNT_WIDTH]`.
- `th_on` in `CNT_WIDTH`: margin threshold that sets `peak_good`.
- `th_off` in `CNT_WIDTH`: margin threshold below which `peak_good` clears.
- `busy` out 1: high while not IDLE.
- `result_vld` out 1: one-cycle pulse when outputs update.
- `max_idx` out `IDX_W`; `max_cnt` out `CNT_WIDTH`; `second_cnt` out `CNT_WIDTH`; `margin` out `CNT_WIDTH`.
- `tie` out 1: margin == 0.
- `peak_good` out 1; `peak_stable` out 1; `stable_cnt` out `STB_W`.
- `scan_count` out 32: number of published results, wraps modulo 2^32.

## Operation
- FSM states: IDLE, SCAN, DONE. State is IDLE after reset.
- IDLE → SCAN on `scan_start` or `auto_rescan`. On that edge:
  - `phase_count` is copied into a snapshot register.
  - `ptr` is set to 0; working max = 0, second = 0, idx = 0.
- SCAN processes element `c = snap[ptr]` once per cycle:
  - if `c > max`: second ← max, max ← c, idx ← ptr
  - else if `c > second`: second ← c
  - `ptr` increments. After `ptr == NUM_PHASE-1` is processed, go to DONE.
- Compares are strict. On a tie the lowest index wins, second equals max, and margin = 0.
- DONE publishes outputs and pulses `result_vld`:
  - `margin = max − second`. It cannot underflow.
  - Hysteresis: if `peak_good` is 0, set it when `margin ≥ th_on`. If `peak_good` is 1, clear it when `margin < th_off`.
  - Stability:
    - If the new `peak_good` is 0: `stable_cnt` ← 0.
    - Else, if `prev_valid` and `max_idx_new == max_idx_old`: `stable_cnt` ← min(`stable_cnt`+1, `STABLE_SCANS`).
    - Otherwise: `stable_cnt` ← 1.
    - `prev_valid` ← 1. `peak_stable` = (`stable_cnt == STABLE_SCANS`).
  - `scan_count` ← `scan_count` + 1.
  - DONE → SCAN (new snapshot, same edge) if `scan_start` or `auto_rescan`; otherwise DONE → IDLE.
- `scan_start` during SCAN is ignored and is not queued.
- `clr` has priority over everything. Next state is IDLE. All outputs return to reset values, `prev_valid` ← 0, and `result_vld` is not pulsed.
- Changes on `phase_count` after the snapshot edge do not affect the scan in progress.
- `th_on`/`th_off` are sampled in DONE only.

## Timing
- Reset and `clr` values: all outputs 0, including `busy`, `result_vld`, `peak_good`, `stable_cnt`, `scan_count`.
- Edge E0 samples start. `busy` is high from E0.
- Edges E1..E_N process the N = `NUM_PHASE` elements.
- Edge E_{N+1} publishes the result. `result_vld` is high for the cycle after E_{N+1`.
- Latency: N+1 cycles, i.e. 17 for the defaults.
- With `auto_rescan` held high, `result_vld` pulses every N+1 cycles and `busy` stays high.
- Published outputs hold between pulses.
- Asynchronous reset mid-scan: immediate return to IDLE with all outputs 0. No partial result is published.

## Structure
- Shared package/header `uwoc_rx_pkg`:
  - FSM state encoding localparams
  - default `th_on` = 50 and `th_off` = 30
  - the phase-slice indexing macro, reused by other RX debug blocks
- One sub-module: `phase_peak_qualifier`. It holds the hysteresis, stability counter and `prev_valid`. It is driven by DONE-cycle `{max_idx, margin, th_on, th_off}` and a publish strobe.
- The scan datapath stays in the top module.

## Test plan
- Counts 0..15 → phase k holds `k*10`, `th_on`=50, `th_off`=30, single start → `result_vld` 17 cycles later; `max_idx`=15, `max_cnt`=150, `second_cnt`=140, `margin`=10, `peak_good`=0.
- Phase 3 = 500, phase 9 = 500, rest 10 → `max_idx`=3, `second_cnt`=500, `tie`=1, `peak_good`=0.
- Margin sequence 60, 40, 25, 55 over four auto scans → `peak_good` 1, 1, 0, 1. `stable_cnt` 1, 2, 0, 1 (same idx).
- Phase 5 dominant (margin 200), `auto_rescan`=1 for 6 scans → `stable_cnt` saturates at 4, `peak_stable`=1 from the 4th pulse. Change dominant phase to 7 → `stable_cnt`=1, `peak_stable`=0.
- Modify `phase_count` mid-scan → result reflects the snapshot only. Pulse `scan_start` during SCAN → no extra `result_vld`.
- Assert `clr` at scan cycle 8, then `rst_n` low at scan cycle 5 on a later run → `busy`=0 next cycle, no `result_vld`, all outputs 0, `scan_count` = 0.
